// File: rtl/axi4_mon_pkg.sv
// Shared constants and types for the AXI4 AW/B channel monitor.
package axi4_mon_pkg;

  localparam int VIOL_UNDERFLOW = 0;
  localparam int VIOL_OVERFLOW  = 1;
  localparam int VIOL_STABLE    = 2;
  localparam int VIOL_TIMEOUT   = 3;
  localparam int VIOL_W         = 4;

  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} axi4_resp_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axi4_b_channel_monitor_if.sv
// AW handshake plus B response bundle; the mon modport observes everything.
interface axi4_b_channel_monitor_if #(
  parameter int ID_W = 4
);

  logic                     aw_valid;
  logic                     aw_ready;
  logic [ID_W-1:0]          aw_id;
  logic                     b_valid;
  logic                     b_ready;
  logic [ID_W-1:0]          b_id;
  axi4_mon_pkg::axi4_resp_e b_resp;

  modport master (output aw_valid, aw_id, b_ready,
                  input  aw_ready, b_valid, b_id, b_resp);

  modport slave  (input  aw_valid, aw_id, b_ready,
                  output aw_ready, b_valid, b_id, b_resp);

  modport mon    (input  aw_valid, aw_ready, aw_id, b_valid, b_ready, b_id, b_resp);

endinterface

// File: rtl/axi4_mon_watchdog.sv
// Saturating progress watchdog: hit pulses once, on the cycle the count first reaches LIMIT.
module axi4_mon_watchdog
  import axi4_mon_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic hit
);

  localparam int            W    = cnt_width(LIMIT);
  localparam logic [W-1:0]  TOP  = W'(LIMIT);
  localparam logic [W-1:0]  LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [W-1:0] count_q;

  // A LIMIT of zero disables the watchdog entirely.
  assign hit = (LIMIT > 0) && enable && !clear && (count_q == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != TOP)) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/axi4_b_channel_monitor.sv
// AXI4 AW/B protocol monitor feeding registered check terms to a fatal-assert block.
// Define AXI4_MON_PER_ID_EN to check B underflow per ID instead of globally.
module axi4_b_channel_monitor
  import axi4_mon_pkg::*;
#(
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                  clock,
  input  logic                                  reset,
  axi4_b_channel_monitor_if.mon                 bus,
  output logic                                  chk_init,
  output logic                                  chk_idle,
  output logic                                  chk_pass,
  output logic [VIOL_W-1:0]                     viol,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0] outstanding
);

  localparam int           CW      = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic              aw_hs, b_hs, inc, dec;
  logic              underflow, overflow, unstable, timeout;
  logic              wd_en, wd_clr;
  logic [CW-1:0]     cnt_q;
  logic              stall_q;
  logic [ID_W-1:0]   cap_id;
  axi4_resp_e        cap_resp;
  logic [VIOL_W-1:0] det;

  assign aw_hs = bus.aw_valid & bus.aw_ready;
  assign b_hs  = bus.b_valid & bus.b_ready;

`ifdef AXI4_MON_PER_ID_EN
  localparam int NUM_ID = 1 << ID_W;

  logic [CW-1:0] id_cnt_q [NUM_ID];

  assign dec = b_hs && (id_cnt_q[bus.b_id] != '0);

  // Per-ID counts always sum to cnt_q, so none can exceed MAX_OUTSTANDING.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ID; i++) id_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ID; i++) begin
        id_cnt_q[i] <= id_cnt_q[i] + CW'(inc && (bus.aw_id == ID_W'(i)))
                                   - CW'(dec && (bus.b_id == ID_W'(i)));
      end
    end
  end
`else
  assign dec = b_hs && (cnt_q != '0);
`endif

  // At the ceiling an AW is only absorbed when a B retires in the same cycle.
  assign inc       = aw_hs && ((cnt_q != CNT_MAX) || dec);
  assign underflow = b_hs && !dec;
  assign overflow  = aw_hs && !b_hs && (cnt_q == CNT_MAX);
  assign unstable  = stall_q && (!bus.b_valid || (bus.b_id != cap_id) || (bus.b_resp != cap_resp));

  assign wd_en  = (cnt_q != '0);
  assign wd_clr = !wd_en || b_hs;

  axi4_mon_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .enable (wd_en),
    .clear  (wd_clr),
    .hit    (timeout)
  );

  always_comb begin
    det                 = '0;
    det[VIOL_UNDERFLOW] = underflow;
    det[VIOL_OVERFLOW]  = overflow;
    det[VIOL_STABLE]    = unstable;
    det[VIOL_TIMEOUT]   = timeout;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk_init <= 1'b1;
      chk_idle <= 1'b1;
      chk_pass <= 1'b1;
      viol     <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      cap_id   <= '0;
      cap_resp <= OKAY;
    end else begin
      chk_init <= 1'b0;
      chk_idle <= !(aw_hs || b_hs || stall_q || (cnt_q != '0));
      chk_pass <= (det == '0);
      viol     <= viol | det;
      cnt_q    <= cnt_q + CW'(inc) - CW'(dec);
      stall_q  <= bus.b_valid && !bus.b_ready;
      if (bus.b_valid && !bus.b_ready) begin
        cap_id   <= bus.b_id;
        cap_resp <= bus.b_resp;
      end
    end
  end

  assign outstanding = cnt_q;

endmodule
